// File: rtl/seg7_pkg.sv
// Shared constants for the two-digit seven-segment to binary converter:
// segment patterns, FSM state encoding and default settle time.
package seg7_pkg;

  // Patterns are {g,f,e,d,c,b,a}, active-high.
  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7D;
  localparam logic [6:0] SEG_7     = 7'h07;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h6F;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  localparam int unsigned STABLE_CYCLES_DEFAULT = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_DECODE,
    ST_HOLD,
    ST_WAIT
  } state_t;

endpackage

// File: rtl/seg7_digit_decode.sv
// Combinational decode of one seven-segment pattern into a BCD digit,
// optionally treating an all-off pattern as zero (leading-digit blanking).
module seg7_digit_decode
  import seg7_pkg::*;
(
  input  logic [6:0] pattern,
  input  logic       allow_blank,
  output logic [3:0] digit,
  output logic       legal
);

  always_comb begin
    digit = 4'd0;
    legal = 1'b1;
    case (pattern)
      SEG_0: digit = 4'd0;
      SEG_1: digit = 4'd1;
      SEG_2: digit = 4'd2;
      SEG_3: digit = 4'd3;
      SEG_4: digit = 4'd4;
      SEG_5: digit = 4'd5;
      SEG_6: digit = 4'd6;
      SEG_7: digit = 4'd7;
      SEG_8: digit = 4'd8;
      SEG_9: digit = 4'd9;
      default: legal = allow_blank && (pattern == SEG_BLANK);
    endcase
  end

endmodule

// File: rtl/seg7_to_bin.sv
// Debounces a two-digit seven-segment display reading and converts it to a
// 4-bit binary value with a valid/ready handshake on the result.
//
// state  | meaning
// IDLE   | first edge after reset: take initial snapshot
// SETTLE | count edges on which inputs match the snapshot
// DECODE | register the decoded result
// HOLD   | result presented, waiting for out_ready
// WAIT   | result consumed, waiting for inputs to change
module seg7_to_bin
  import seg7_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = STABLE_CYCLES_DEFAULT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] seg_tens,
  input  logic [6:0] seg_ones,
  input  logic       out_ready,
  output logic       out_valid,
  output logic [3:0] out_bin,
  output logic       out_err
);

  localparam logic [7:0] STABLE_TC = 8'(STABLE_CYCLES);

  state_t      state;
  logic [13:0] snap;
  logic [7:0]  cnt;
  logic [13:0] seg_in;
  logic [3:0]  tens_dig;
  logic [3:0]  ones_dig;
  logic        tens_ok;
  logic        ones_ok;
  logic [4:0]  value;
  logic        decode_bad;

  assign seg_in = {seg_tens, seg_ones};

  seg7_digit_decode u_dec_tens (
    .pattern     (snap[13:7]),
    .allow_blank (1'b1),
    .digit       (tens_dig),
    .legal       (tens_ok)
  );

  seg7_digit_decode u_dec_ones (
    .pattern     (snap[6:0]),
    .allow_blank (1'b0),
    .digit       (ones_dig),
    .legal       (ones_ok)
  );

  // Tens above 1 is already out of range and would overflow the 5-bit sum.
  assign value      = {1'b0, tens_dig} * 5'd10 + {1'b0, ones_dig};
  assign decode_bad = !tens_ok || !ones_ok || (tens_dig > 4'd1) || (value > 5'd15);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      snap      <= '0;
      cnt       <= '0;
      out_valid <= 1'b0;
      out_bin   <= '0;
      out_err   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          snap  <= seg_in;
          cnt   <= '0;
          state <= ST_SETTLE;
        end
        ST_SETTLE: begin
          if (seg_in != snap) begin
            snap <= seg_in;
            cnt  <= '0;
          end else begin
            cnt <= cnt + 8'd1;
            if (cnt + 8'd1 == STABLE_TC) state <= ST_DECODE;
          end
        end
        ST_DECODE: begin
          out_valid <= 1'b1;
          out_err   <= decode_bad;
          out_bin   <= decode_bad ? 4'd0 : value[3:0];
          state     <= ST_HOLD;
        end
        ST_HOLD: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (seg_in != snap) begin
            snap  <= seg_in;
            cnt   <= '0;
            state <= ST_SETTLE;
          end
        end
        default: begin
          out_valid <= 1'b0;
          state     <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/seg7_to_bin.md
SEG7_TO_BIN -- requirements
Module: seg7_to_bin

Interface
REQ-001 Parameter STABLE_CYCLES, default 4, gives the number of consecutive clock edges both segment inputs SHALL match the snapshot before decoding (legal 1..255).
REQ-002 clk  input  1  single system clock; all state SHALL update on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous and active-low.
REQ-004 seg_tens  input  7  tens-digit pattern, {g,f,e,d,c,b,a}, active-high.
REQ-005 seg_ones  input  7  ones-digit pattern, same encoding as seg_tens.
REQ-006 out_ready  input  1  consumer accepts the result on any edge where out_valid=1 and out_ready=1.
REQ-007 out_valid  output  1  out_bin and out_err hold a result.
REQ-008 out_bin  output  4  decoded binary value 0..15.
REQ-009 out_err  output  1  result is invalid (illegal pattern or value >15).

Function
REQ-010 Digit patterns SHALL be: 0=0x3F, 1=0x06, 2=0x5B, 3=0x4F, 4=0x66, 5=0x6D, 6=0x7D, 7=0x07, 8=0x7F, 9=0x6F; any other pattern is illegal.
REQ-011 On seg_tens, blank (0x00) SHALL decode as digit 0, in addition to 0x3F.
REQ-012 FSM states SHALL be IDLE, SETTLE, DECODE, HOLD and WAIT.
REQ-013 IDLE: on the next edge, capture {seg_tens,seg_ones} into the snapshot, clear the counter and go to SETTLE.
REQ-014 SETTLE: on each edge where the inputs equal the snapshot, increment the counter; when it reaches STABLE_CYCLES, go to DECODE.
REQ-015 SETTLE: on any edge where the inputs differ from the snapshot, recapture the snapshot, clear the counter and stay in SETTLE.
REQ-016 DECODE: in one cycle, register value = tens*10 + ones using a 5-bit intermediate, then go to HOLD.
REQ-017 If either digit is illegal or value > 15, DECODE SHALL register out_err=1 and out_bin=0; otherwise out_err=0 and out_bin=value[3:0].
REQ-018 Latency: with inputs constant from first sampling edge k, out_valid SHALL rise after edge k+STABLE_CYCLES+1.
REQ-019 HOLD: out_valid=1; out_bin and out_err SHALL stay stable until the accept edge; input changes during HOLD SHALL be ignored.
REQ-020 On the accept edge, clear out_valid and go to WAIT; out_bin and out_err keep their last value.
REQ-021 WAIT: on the first edge where the inputs differ from the snapshot, recapture the snapshot, clear the counter and go to SETTLE; identical inputs SHALL NOT produce a second result.
REQ-022 out_valid SHALL be 1 only in HOLD and SHALL be registered (no combinational path from the inputs).

Reset
REQ-023 While rst_n=0: state=IDLE, snapshot=0, counter=0, out_valid=0, out_bin=0, out_err=0, applied asynchronously.
REQ-024 Reset asserted mid-operation (SETTLE, DECODE or HOLD) SHALL discard the pending result, with no out_valid pulse after release.
REQ-025 First capture SHALL occur on the first rising edge after rst_n deasserts.

Structure
REQ-026 Package seg7_pkg SHALL hold the ten segment constants, the blank constant, the FSM state encoding and the default STABLE_CYCLES.
REQ-027 A combinational sub-module seg7_digit_decode (7-bit pattern to 4-bit digit plus legal flag, with an allow_blank input) SHALL be instantiated once per digit.
REQ-028 The counter width SHALL be 8 bits, with saturation impossible because STABLE_CYCLES <= 255.

Verification
REQ-029 Tens=0x06, ones=0x6D held, out_ready=1 -> out_valid pulses 1 cycle after edge k+5, out_bin=0xF, out_err=0.
REQ-030 Tens=0x00, ones=0x7D -> out_bin=6, out_err=0; tens=0x06, ones=0x7F (18) -> out_bin=0, out_err=1.
REQ-031 Ones=0x01 (illegal) -> out_err=1, out_bin=0.
REQ-032 Ones toggles 0x06/0x5B every 3 cycles with STABLE_CYCLES=4 -> out_valid never asserts; once held at 0x5B -> out_bin=2.
REQ-033 out_ready=0 for 10 cycles while inputs change -> out_valid and out_bin stay constant, then one accept, then a new result follows the changed input.
REQ-034 rst_n pulsed low in SETTLE and again in HOLD -> all outputs 0 immediately, no stale out_valid after release; same input held after accept -> no second out_valid.
